kb_func_select: RTL
===================

# kb_func_select

Parametrised PS/2 function-key selector; successor to the fixed three-key keyboard decoder. Sits between the PS/2 scan-code receiver and the configuration controller. Consumes make/break scan codes with their strobe and holds a one-hot selection over N_FUNC function keys. Issues a confirm request that stays asserted until the controller acknowledges it.

## Interface
- N_FUNC, 3: number of selectable function keys (1..16).
- CW, 8: scan-code width.
- FUNC_CODES, {8'h04,8'h06,8'h05}: packed N_FUNC×CW make codes; slice i (LSB-first) selects function i (default: F1=05, F2=06, F3=04).
- CONF_CODE, 8'h79: confirm key (keypad +).
- CANCEL_CODE, 8'h76: cancel key (Esc).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- key_code  in  CW  scan code from receiver; valid only with got_code_tick.
- got_code_tick  in  1  one-cycle strobe, one per received code.
- ack  in  1  controller has taken the confirmed selection.
- sel  out  N_FUNC  one-hot current selection; all-zero means none.
- sel_idx  out  $clog2(N_FUNC)+1  binary index of sel; all-ones means none.
- conf_valid  out  1  confirm request; held until ack.
- conf_sel  out  N_FUNC  selection frozen at confirm.
- err_tick  out  1  one-cycle pulse: confirm pressed with no selection.

## Operation
- FSM states: IDLE, BREAK, EXT.
  - IDLE + tick with 8'hF0 -> BREAK.
  - IDLE + tick with 8'hE0 -> EXT.
  - BREAK + any tick -> IDLE. The released key is discarded.
  - EXT + tick with F0 -> BREAK. EXT + any other tick -> IDLE. Extended make codes never match the tables.
- Make code in IDLE:
  - Matches FUNC_CODES slice i: sel <= one-hot i, replacing any prior selection.
  - Matches more than one slice: the lowest i wins.
  - Matches CANCEL_CODE: sel <= 0.
  - Matches CONF_CODE with sel != 0: conf_valid <= 1 and conf_sel <= sel.
  - Matches CONF_CODE with sel == 0: err_tick pulses and conf_valid is unchanged.
  - Any other code is ignored.
- While conf_valid = 1:
  - Function, cancel and confirm keys are ignored. The selection is locked.
  - The FSM still tracks F0/E0 so that framing stays aligned.
- When ack = 1 with conf_valid = 1: conf_valid <= 0, sel <= 0, and conf_sel keeps its value.
- ack while conf_valid = 0 has no effect.
- ack and tick in the same cycle: ack is applied first. The tick is then processed as if conf_valid = 0.

## Timing
- All outputs are registered. They update on the clk edge that samples got_code_tick, so they are visible the next cycle (latency 1).
- err_tick is exactly one cycle wide.
- Reset (reset = 0 at a clk edge): state = IDLE, sel = 0, sel_idx = all-ones, conf_valid = 0, conf_sel = 0, err_tick = 0. Reset wins over tick and ack in the same cycle.
- Reset in the middle of an F0 or E0 sequence drops the prefix. The next code is treated as a make code.
- got_code_tick on consecutive cycles is legal. Each tick is processed independently.

## Configuration
- KB_TYPEMATIC_FILTER_EN defined:
  - A per-key "held" flag (N_FUNC+2 bits) is set on make and cleared on the matching break.
  - Repeated make codes of a held key are ignored, so auto-repeat of CONF_CODE cannot re-trigger err_tick.
  - Flags clear on reset.
- KB_TYPEMATIC_FILTER_EN undefined: every make code is processed. No held-flag storage is present.

## Structure
- Package kb_pkg:
  - BREAK_CODE (8'hF0), EXT_CODE (8'hE0).
  - FSM state typedef kb_state_t {IDLE, BREAK, EXT}.
  - Default key-code constants.
- Sub-module kb_code_match: combinational. Inputs are key_code and FUNC_CODES. Outputs are the hit vector, the lowest-index one-hot, and the any-hit flag.
  - Instantiated once.
  - Also reused for the held-flag lookup when the filter is enabled.

## Test plan
- Reset low, then tick 05 -> next cycle sel = 001, sel_idx = 0. Then tick 04 -> sel = 100, sel_idx = 2.
- Tick 06, F0, 06 -> sel = 010 after the make. The break leaves sel at 010 and the FSM returns to IDLE.
- Tick 05, 79 -> conf_valid = 1, conf_sel = 001. Tick 06 -> sel stays 001. Pulse ack -> conf_valid = 0, sel = 000, conf_sel = 001.
- From reset, tick 79 -> err_tick high for exactly 1 cycle, conf_valid = 0. Tick 05, 76 -> sel = 000.
- Tick E0, 05 -> sel unchanged (extended code ignored). ack coincident with tick 06 while conf_valid = 1 -> conf_valid = 0 and sel = 010.
- With KB_TYPEMATIC_FILTER_EN, from reset: tick 79, 79, 79 -> one err_tick only. Tick F0, 79, then 79 -> a second err_tick.

Source files
------------

// File: rtl/kb_pkg.sv
// kb_pkg: shared definitions for the PS/2 function-key selector.
//   - PS/2 framing prefixes (break and extended).
//   - FSM state encoding for the scan-code framer.
//   - Default key-code tables (F1/F2/F3, keypad +, Esc).
package kb_pkg;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;

  // Slice i (LSB-first) selects function i: F1=05, F2=06, F3=04.
  localparam logic [23:0] DEF_FUNC_CODES  = {8'h04, 8'h06, 8'h05};
  localparam logic [7:0]  DEF_CONF_CODE   = 8'h79;
  localparam logic [7:0]  DEF_CANCEL_CODE = 8'h76;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BREAK = 2'd1,
    EXT   = 2'd2
  } kb_state_t;

endpackage

// File: rtl/kb_code_match.sv
// kb_code_match: combinational lookup of a scan code in a packed code table.
// Ports:
//   key_code  in  CW        code to look up
//   codes     in  N*CW      packed table, slice i (LSB-first) is entry i
//   hit       out N         bit i set when key_code equals entry i
//   first     out N         one-hot of the lowest-index hit (zero if none)
//   any_hit   out 1         at least one entry matched
module kb_code_match #(
  parameter int N  = 3,
  parameter int CW = 8
) (
  input  logic [CW-1:0]   key_code,
  input  logic [N*CW-1:0] codes,
  output logic [N-1:0]    hit,
  output logic [N-1:0]    first,
  output logic            any_hit
);

  always_comb begin
    hit = '0;
    for (int i = 0; i < N; i++) begin
      hit[i] = (codes[i*CW +: CW] == key_code);
    end
  end

  // Isolate the lowest set bit so duplicate table entries resolve to the
  // lowest function index.
  assign first   = hit & (~hit + N'(1));
  assign any_hit = |hit;

endmodule

// File: rtl/kb_func_select.sv
// kb_func_select: PS/2 function-key selector.
// Consumes make/break scan codes and holds a one-hot selection over N_FUNC
// function keys; a confirm key raises a request that is held until acked.
//
// Handshake: conf_valid rises with conf_sel frozen; it stays high (and the
// selection stays locked) until a cycle in which ack=1, after which
// conf_valid and sel clear on the next edge. ack with conf_valid=0 is a
// no-op. An ack in the same cycle as a tick is applied before the tick.
//
// Ports:
//   clk            in   system clock
//   reset          in   synchronous active-low reset
//   key_code       in   CW-bit scan code, valid with got_code_tick
//   got_code_tick  in   one-cycle strobe per received code
//   ack            in   controller took the confirmed selection
//   sel            out  one-hot current selection (zero = none)
//   sel_idx        out  binary index of sel (all-ones = none)
//   conf_valid     out  confirm request, held until ack
//   conf_sel       out  selection frozen at confirm
//   err_tick       out  one-cycle pulse: confirm with no selection
//   state_dbg      out  framer FSM state (kb_state_t encoding)
//
// Build option: KB_TYPEMATIC_FILTER_EN adds per-key held flags that drop
// auto-repeated make codes until the matching break arrives.
module kb_func_select
  import kb_pkg::*;
#(
  parameter int                    N_FUNC      = 3,
  parameter int                    CW          = 8,
  parameter logic [N_FUNC*CW-1:0]  FUNC_CODES  = DEF_FUNC_CODES,
  parameter logic [CW-1:0]         CONF_CODE   = DEF_CONF_CODE,
  parameter logic [CW-1:0]         CANCEL_CODE = DEF_CANCEL_CODE
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [CW-1:0]               key_code,
  input  logic                        got_code_tick,
  input  logic                        ack,
  output logic [N_FUNC-1:0]           sel,
  output logic [$clog2(N_FUNC):0]     sel_idx,
  output logic                        conf_valid,
  output logic [N_FUNC-1:0]           conf_sel,
  output logic                        err_tick,
  output logic [1:0]                  state_dbg
);

  localparam int IW = $clog2(N_FUNC) + 1;

  kb_state_t            state_q, state_n;
  logic [N_FUNC-1:0]    sel_n, conf_sel_n;
  logic [IW-1:0]        sel_idx_n;
  logic                 conf_valid_n, err_n;

  logic [N_FUNC-1:0]    func_hit, func_first;
  logic                 func_any;
  logic                 cancel_m, conf_m;
  logic                 is_break, is_ext;
  logic                 make_ok;

  kb_code_match #(.N(N_FUNC), .CW(CW)) u_match (
    .key_code (key_code),
    .codes    (FUNC_CODES),
    .hit      (func_hit),
    .first    (func_first),
    .any_hit  (func_any)
  );

  // Only the prioritised one-hot drives the selection.
  logic func_hit_unused;
  assign func_hit_unused = ^func_hit;

  assign cancel_m = (key_code == CANCEL_CODE);
  assign conf_m   = (key_code == CONF_CODE);
  assign is_break = (key_code == CW'(BREAK_CODE));
  assign is_ext   = (key_code == CW'(EXT_CODE));

`ifdef KB_TYPEMATIC_FILTER_EN
  // Held flags: [N_FUNC-1:0] function keys, [N_FUNC] cancel, [N_FUNC+1] confirm.
  logic [N_FUNC+1:0] held_q, held_n, key_oh;
  assign key_oh = {conf_m & ~func_any & ~cancel_m,
                   cancel_m & ~func_any,
                   func_first};
  assign make_ok = ~|(held_q & key_oh);
`else
  assign make_ok = 1'b1;
`endif

  always_comb begin
    logic                cv_eff;
    logic [N_FUNC-1:0]   sel_base;
    state_n      = state_q;
    // ack takes effect before any tick in the same cycle.
    cv_eff       = conf_valid & ~ack;
    sel_base     = (conf_valid & ack) ? '0 : sel;
    sel_n        = sel_base;
    conf_valid_n = cv_eff;
    conf_sel_n   = conf_sel;
    err_n        = 1'b0;
`ifdef KB_TYPEMATIC_FILTER_EN
    held_n       = held_q;
`endif
    if (got_code_tick) begin
      unique case (state_q)
        IDLE: begin
          if (is_break) begin
            state_n = BREAK;
          end else if (is_ext) begin
            state_n = EXT;
          end else begin
`ifdef KB_TYPEMATIC_FILTER_EN
            held_n = held_q | key_oh;
`endif
            // Selection is locked while a confirm request is pending.
            if (make_ok && !cv_eff) begin
              if (func_any) begin
                sel_n = func_first;
              end else if (cancel_m) begin
                sel_n = '0;
              end else if (conf_m) begin
                if (sel_base != '0) begin
                  conf_valid_n = 1'b1;
                  conf_sel_n   = sel_base;
                end else begin
                  err_n = 1'b1;
                end
              end
            end
          end
        end
        BREAK: begin
`ifdef KB_TYPEMATIC_FILTER_EN
          held_n = held_q & ~key_oh;
`endif
          state_n = IDLE;
        end
        EXT: begin
          state_n = is_break ? BREAK : IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    sel_idx_n = '1;
    for (int i = 0; i < N_FUNC; i++) begin
      if (sel_n[i]) sel_idx_n = IW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      sel        <= '0;
      sel_idx    <= '1;
      conf_valid <= 1'b0;
      conf_sel   <= '0;
      err_tick   <= 1'b0;
    end else begin
      state_q    <= state_n;
      sel        <= sel_n;
      sel_idx    <= sel_idx_n;
      conf_valid <= conf_valid_n;
      conf_sel   <= conf_sel_n;
      err_tick   <= err_n;
    end
  end

`ifdef KB_TYPEMATIC_FILTER_EN
  always_ff @(posedge clk) begin
    if (!reset) held_q <= '0;
    else        held_q <= held_n;
  end
`endif

  assign state_dbg = state_q;

endmodule
